binary_threshold_stage: RTL and testbench

//  Pipelined binarizer between image_read and image_write. Consumes two RGB pixels per

---
 rtl/binary_threshold_stage_pkg.sv | 22 ++
 rtl/binary_threshold_stage_if.sv | 14 +
 rtl/binary_threshold_stage_divider.sv | 56 +++++
 rtl/binary_threshold_stage.sv | 104 ++++++++++
 tb/tb_binary_threshold_stage.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/binary_threshold_stage_pkg.sv
// binary_threshold_stage_pkg: frame geometry, luma coefficients, output levels and FSM states
package binary_threshold_stage_pkg;
    localparam int WIDTH = 768;
    localparam int HEIGHT = 512;
    localparam int FRAME_BEATS = WIDTH * HEIGHT / 2;
    localparam logic [7:0] THRESHOLD = 8'd128;
    localparam int PIPE_LAT = 3;
    localparam int DIV_W = 27;
    localparam logic [7:0] K_R = 8'd77;
    localparam logic [7:0] K_G = 8'd150;
    localparam logic [7:0] K_B = 8'd29;
    localparam logic [7:0] BLACK = 8'h00;
    localparam logic [7:0] WHITE = 8'hFF;
    typedef enum logic [1:0] {IDLE, STREAM, DIVIDE, UPDATE} state_t;
    // channel index within a pixel: 2=R, 1=G, 0=B
    function automatic logic [7:0] coef(input int c);
        return c == 2 ? K_R : c == 1 ? K_G : K_B;
    endfunction
    function automatic logic [7:0] binarize(input logic [7:0] y, input logic [7:0] thr, input logic inv);
        return ((y >= thr) ? WHITE : BLACK) ^ {8{inv}};
    endfunction
endpackage

// File: rtl/binary_threshold_stage_if.sv
// binary_threshold_stage_if: pixel-pair stream into the stage and binarized stream out of it
interface binary_threshold_stage_if;
    logic       hsync_in, vsync_in, hsync_out, vsync_out;
    logic [7:0] DATA_R0_IN, DATA_G0_IN, DATA_B0_IN, DATA_R1_IN, DATA_G1_IN, DATA_B1_IN;
    logic [7:0] DATA_R0_OUT, DATA_G0_OUT, DATA_B0_OUT, DATA_R1_OUT, DATA_G1_OUT, DATA_B1_OUT;
    modport master (
        output hsync_in, vsync_in, DATA_R0_IN, DATA_G0_IN, DATA_B0_IN, DATA_R1_IN, DATA_G1_IN, DATA_B1_IN,
        input  hsync_out, vsync_out, DATA_R0_OUT, DATA_G0_OUT, DATA_B0_OUT, DATA_R1_OUT, DATA_G1_OUT, DATA_B1_OUT
    );
    modport slave (
        input  hsync_in, vsync_in, DATA_R0_IN, DATA_G0_IN, DATA_B0_IN, DATA_R1_IN, DATA_G1_IN, DATA_B1_IN,
        output hsync_out, vsync_out, DATA_R0_OUT, DATA_G0_OUT, DATA_B0_OUT, DATA_R1_OUT, DATA_G1_OUT, DATA_B1_OUT
    );
endinterface

// File: rtl/binary_threshold_stage_divider.sv
// seq_divider: restoring divider, one quotient bit per cycle, done pulses after the last bit
module seq_divider #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);
    localparam int CW = $clog2(W + 1);
    logic [W-1:0] rem_q, rem_d, quo_q, quo_d;
    logic [W:0] rem_sh, diff;
    logic [CW-1:0] cnt_q, cnt_d;
    logic busy_q, busy_d, done_q, done_d;
    always_comb begin
        rem_sh = {rem_q, quo_q[W-1]};
        diff = rem_sh - {1'b0, divisor};
        rem_d = rem_q;
        quo_d = quo_q;
        cnt_d = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            cnt_d = CW'(W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
            quo_d = {quo_q[W-2:0], ~diff[W]};
            cnt_d = cnt_q - 1'b1;
            busy_d = cnt_q != CW'(1);
            done_d = cnt_q == CW'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign quotient = quo_q;
    assign done = done_q;
endmodule

// File: rtl/binary_threshold_stage.sv
// binary_threshold_stage: 3-stage luma binarizer; threshold is static or the previous frame's mean luma
module binary_threshold_stage #(
    parameter int WIDTH = binary_threshold_stage_pkg::WIDTH,
    parameter int HEIGHT = binary_threshold_stage_pkg::HEIGHT,
    parameter logic [7:0] THRESHOLD = binary_threshold_stage_pkg::THRESHOLD
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    binary_threshold_stage_if.slave bus,
    input  logic [7:0]              threshold_cfg,
    input  logic                    adaptive_en,
    input  logic                    invert_en,
    output logic [7:0]              cur_threshold,
    output logic                    frame_done
);
    import binary_threshold_stage_pkg::*;
    localparam int FB = WIDTH * HEIGHT / 2;
    localparam int CW = $clog2(FB + 1);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] cur_thr_q, cur_thr_d, next_thr_q, next_thr_d, thr1_q, thr1_d, thr2_q, thr2_d;
    logic [5:0][15:0] prod_q, prod_d;
    logic [1:0][7:0] y_q, y_d, pix_q, pix_d;
    logic [2:0] hs_q, hs_d, vs_q, vs_d;
    logic [1:0] last_q, last_d;
    logic [DIV_W-1:0] acc_q, acc_d, quotient;
    logic fd_q, fd_d, leave, div_start, div_done;
    logic [5:0][7:0] px;
    assign px = {bus.DATA_R0_IN, bus.DATA_G0_IN, bus.DATA_B0_IN, bus.DATA_R1_IN, bus.DATA_G1_IN, bus.DATA_B1_IN};
    // the threshold travels with each beat so frame boundaries never mix thresholds in flight
    always_comb begin
        leave = hs_q[1] & last_q[1];
        div_start = leave && state_q != DIVIDE;
        cnt_d = bus.hsync_in ? ((cnt_q == CW'(FB - 1)) ? '0 : cnt_q + 1'b1) : cnt_q;
        cur_thr_d = (bus.hsync_in && cnt_q == '0) ? (adaptive_en ? next_thr_q : threshold_cfg) : cur_thr_q;
        thr1_d = bus.hsync_in ? cur_thr_d : thr1_q;
        thr2_d = hs_q[0] ? thr1_q : thr2_q;
        hs_d = {hs_q[1:0], bus.hsync_in};
        vs_d = {vs_q[1:0], bus.vsync_in};
        last_d = {last_q[0], cnt_q == CW'(FB - 1)};
        for (int i = 0; i < 6; i++) prod_d[i] = bus.hsync_in ? 16'(px[i]) * 16'(coef(i % 3)) : prod_q[i];
        for (int j = 0; j < 2; j++) y_d[j] = hs_q[0] ? 8'((prod_q[3*j] + prod_q[3*j+1] + prod_q[3*j+2]) >> 8) : y_q[j];
        for (int j = 0; j < 2; j++) pix_d[j] = hs_q[1] ? binarize(y_q[j], thr2_q, invert_en) : pix_q[j];
        acc_d = (leave ? '0 : acc_q) + (hs_q[0] ? DIV_W'(y_d[0]) + DIV_W'(y_d[1]) : '0);
        fd_d = leave;
        next_thr_d = state_q == UPDATE ? (quotient > DIV_W'(255) ? 8'hFF : quotient[7:0]) : next_thr_q;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = div_start ? DIVIDE : bus.hsync_in ? STREAM : IDLE;
            STREAM:  state_d = div_start ? DIVIDE : STREAM;
            DIVIDE:  state_d = div_done ? UPDATE : DIVIDE;
            default: state_d = div_start ? DIVIDE : (cnt_q != '0 || bus.hsync_in) ? STREAM : IDLE;
        endcase
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            cnt_q <= '0;
            cur_thr_q <= THRESHOLD;
            next_thr_q <= THRESHOLD;
            thr1_q <= THRESHOLD;
            thr2_q <= THRESHOLD;
            prod_q <= '0;
            y_q <= '0;
            pix_q <= '0;
            hs_q <= '0;
            vs_q <= '0;
            last_q <= '0;
            acc_q <= '0;
            fd_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            cur_thr_q <= cur_thr_d;
            next_thr_q <= next_thr_d;
            thr1_q <= thr1_d;
            thr2_q <= thr2_d;
            prod_q <= prod_d;
            y_q <= y_d;
            pix_q <= pix_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            last_q <= last_d;
            acc_q <= acc_d;
            fd_q <= fd_d;
        end
    end
    // the dividend is captured at start, so the next frame may accumulate meanwhile
    seq_divider #(.W(DIV_W)) u_div (
        .clk(HCLK),
        .rst_n(HRESETn),
        .start(div_start),
        .dividend(acc_q),
        .divisor(DIV_W'(WIDTH * HEIGHT)),
        .quotient(quotient),
        .done(div_done)
    );
    assign bus.hsync_out = hs_q[2];
    assign bus.vsync_out = vs_q[2];
    assign {bus.DATA_R0_OUT, bus.DATA_G0_OUT, bus.DATA_B0_OUT} = {3{pix_q[1]}};
    assign {bus.DATA_R1_OUT, bus.DATA_G1_OUT, bus.DATA_B1_OUT} = {3{pix_q[0]}};
    assign cur_threshold = cur_thr_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_binary_threshold_stage.sv
// tb_binary_threshold_stage: scoreboard bench on a 4x2 frame (4 beats) so adaptive frames stay short
module tb_binary_threshold_stage;
    localparam int W = 4, H = 2, FB = W * H / 2;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    logic [7:0] threshold_cfg = 8'd128;
    logic [7:0] cur_threshold;
    logic adaptive_en = 1'b0, invert_en = 1'b0, frame_done;
    int tests = 0, fails = 0;
    typedef struct {logic [7:0] p0; logic [7:0] p1; logic vs; logic last;} exp_t;
    exp_t sb[$];
    exp_t held;
    int beat_n = 0, fd_seen = 0, luma_sum = 0, last_mean = 128;
    logic [7:0] exp_next = 8'd128, frame_thr = 8'd128;

    always #5 HCLK = ~HCLK;

    binary_threshold_stage_if bus();
    binary_threshold_stage #(.WIDTH(W), .HEIGHT(H)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus), .threshold_cfg(threshold_cfg),
        .adaptive_en(adaptive_en), .invert_en(invert_en), .cur_threshold(cur_threshold), .frame_done(frame_done)
    );

    function automatic int luma(input int r, input int g, input int b);
        return (77 * r + 150 * g + 29 * b) >> 8;
    endfunction

    task automatic drive_idle_inputs();
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b0;
        {bus.DATA_R0_IN, bus.DATA_G0_IN, bus.DATA_B0_IN, bus.DATA_R1_IN, bus.DATA_G1_IN, bus.DATA_B1_IN} = '0;
    endtask

    task automatic model_reset();
        sb.delete();
        beat_n = 0;
        luma_sum = 0;
        exp_next = 8'd128;
        held = '{p0: 8'h00, p1: 8'h00, vs: 1'b0, last: 1'b0};
    endtask

    task automatic tick();
        exp_t e;
        logic [49:0] got, want;
        @(posedge HCLK);
        #1;
        tests++;
        got = {bus.DATA_R0_OUT, bus.DATA_G0_OUT, bus.DATA_B0_OUT, bus.DATA_R1_OUT, bus.DATA_G1_OUT, bus.DATA_B1_OUT, bus.vsync_out, frame_done};
        if (bus.hsync_out) begin
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_underflow: hsync_out=1 but no beat is expected");
            end else begin
                e = sb.pop_front();
                want = {{3{e.p0}}, {3{e.p1}}, e.vs, e.last};
                if (got !== want) begin
                    fails++;
                    $display("FAIL beat_out: got %h expected %h (pix0x3,pix1x3,vsync,frame_done)", got, want);
                end
                held = e;
                if (frame_done) fd_seen++;
            end
        end else begin
            want = {{3{held.p0}}, {3{held.p1}}, bus.vsync_out, 1'b0};
            if (got !== want) begin
                fails++;
                $display("FAIL bubble_hold: got %h expected %h", got, want);
            end
        end
    endtask

    task automatic beat(input int r0, input int g0, input int b0, input int r1, input int g1, input int b1);
        int y0, y1;
        logic [7:0] inv;
        y0 = luma(r0, g0, b0);
        y1 = luma(r1, g1, b1);
        if (beat_n == 0) frame_thr = adaptive_en ? exp_next : threshold_cfg;
        inv = {8{invert_en}};
        bus.hsync_in = 1'b1;
        bus.vsync_in = beat_n == 0;
        {bus.DATA_R0_IN, bus.DATA_G0_IN, bus.DATA_B0_IN} = {8'(r0), 8'(g0), 8'(b0)};
        {bus.DATA_R1_IN, bus.DATA_G1_IN, bus.DATA_B1_IN} = {8'(r1), 8'(g1), 8'(b1)};
        sb.push_back('{p0: ((y0 >= int'(frame_thr)) ? 8'hFF : 8'h00) ^ inv,
                       p1: ((y1 >= int'(frame_thr)) ? 8'hFF : 8'h00) ^ inv,
                       vs: beat_n == 0, last: beat_n == FB - 1});
        luma_sum += y0 + y1;
        if (beat_n == FB - 1) begin
            last_mean = luma_sum / (W * H);
            luma_sum = 0;
            beat_n = 0;
        end else beat_n++;
        tick();
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b0;
    endtask

    task automatic gray(input int a, input int b);
        beat(a, a, a, b, b, b);
    endtask

    // a long enough gap lets the divider publish the last completed frame's mean
    task automatic idle(input int n);
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b0;
        repeat (n) tick();
        if (n >= 40) exp_next = 8'(last_mean);
    endtask

    task automatic hard_reset();
        HRESETn = 1'b0;
        drive_idle_inputs();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        model_reset();
    endtask

    task automatic drain_check(input string name);
        idle(4);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d beats never appeared, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        logic [52:0] got;
        drive_idle_inputs();
        model_reset();
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        tests++;
        got = {bus.DATA_R0_OUT, bus.DATA_G0_OUT, bus.DATA_B0_OUT, bus.DATA_R1_OUT, bus.DATA_G1_OUT, bus.DATA_B1_OUT,
               bus.hsync_out, bus.vsync_out, frame_done, 2'b00};
        if (got !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0", got);
        end
        tests++;
        if (cur_threshold !== 8'd128) begin
            fails++;
            $display("FAIL reset_threshold: got %0d expected 128", cur_threshold);
        end
        #4;
        HRESETn = 1'b1;
    endtask

    task automatic test_static();
        threshold_cfg = 8'd128;
        adaptive_en = 1'b0;
        invert_en = 1'b0;
        gray(200, 50);
        gray(128, 127);
        beat(255, 0, 0, 0, 255, 0);
        beat(0, 0, 255, 255, 255, 255);
        tests++;
        if (cur_threshold !== 8'd128) begin
            fails++;
            $display("FAIL static_threshold: got %0d expected 128", cur_threshold);
        end
        drain_check("static");
    endtask

    task automatic test_invert();
        invert_en = 1'b1;
        gray(200, 50);
        gray(128, 127);
        gray(127, 128);
        gray(0, 255);
        drain_check("invert");
        invert_en = 1'b0;
    endtask

    task automatic test_adaptive();
        hard_reset();
        adaptive_en = 1'b1;
        threshold_cfg = 8'd200;
        repeat (FB) gray(64, 64);
        idle(40);
        gray(63, 64);
        tests++;
        if (cur_threshold !== 8'd64) begin
            fails++;
            $display("FAIL adaptive_threshold: got %0d expected 64", cur_threshold);
        end
        repeat (FB - 1) gray(63, 64);
        drain_check("adaptive");
    endtask

    task automatic test_overlap();
        int fd0;
        hard_reset();
        adaptive_en = 1'b1;
        fd0 = fd_seen;
        repeat (FB) gray(64, 64);
        idle(1);
        gray(100, 128);
        tests++;
        if (cur_threshold !== 8'd128) begin
            fails++;
            $display("FAIL overlap_stale_threshold: got %0d expected 128", cur_threshold);
        end
        gray(28, 0);
        gray(100, 128);
        gray(28, 0);
        idle(40);
        gray(63, 64);
        tests++;
        if (cur_threshold !== 8'd64) begin
            fails++;
            $display("FAIL overlap_next_threshold: got %0d expected 64", cur_threshold);
        end
        repeat (FB - 1) gray(64, 63);
        drain_check("overlap");
        tests++;
        if (fd_seen - fd0 != 3) begin
            fails++;
            $display("FAIL overlap_frame_done_count: got %0d expected 3", fd_seen - fd0);
        end
    endtask

    task automatic test_bubbles();
        int fd0;
        adaptive_en = 1'b0;
        threshold_cfg = 8'd100;
        fd0 = fd_seen;
        for (int n = 0; n < 3 * FB; n++) begin
            for (int k = 0; k < 4 && $urandom_range(0, 1) == 1; k++) idle(1);
            beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        end
        drain_check("bubbles");
        tests++;
        if (fd_seen - fd0 != 3) begin
            fails++;
            $display("FAIL bubbles_frame_done_count: got %0d expected 3", fd_seen - fd0);
        end
        tests++;
        if (cur_threshold !== 8'd100) begin
            fails++;
            $display("FAIL bubbles_threshold: got %0d expected 100", cur_threshold);
        end
    endtask

    task automatic test_midreset();
        logic [50:0] got;
        adaptive_en = 1'b0;
        threshold_cfg = 8'd50;
        repeat (3) gray(200, 10);
        #2;
        HRESETn = 1'b0;
        #1;
        tests++;
        got = {bus.DATA_R0_OUT, bus.DATA_G0_OUT, bus.DATA_B0_OUT, bus.DATA_R1_OUT, bus.DATA_G1_OUT, bus.DATA_B1_OUT,
               bus.hsync_out, bus.vsync_out, frame_done};
        if (got !== '0 || cur_threshold !== 8'd128) begin
            fails++;
            $display("FAIL midreset_async: outputs %h thr %0d expected outputs 0 thr 128", got, cur_threshold);
        end
        #1;
        HRESETn = 1'b1;
        model_reset();
        gray(49, 50);
        tests++;
        if (cur_threshold !== 8'd50) begin
            fails++;
            $display("FAIL midreset_restart: got threshold %0d expected 50", cur_threshold);
        end
        repeat (FB - 1) gray(50, 49);
        drain_check("midreset");
    endtask

    initial begin
        test_reset();
        test_static();
        test_invert();
        test_adaptive();
        test_overlap();
        test_bubbles();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
